// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access types, fault codes, FSM states.
package lsu_pkg;

    // Load type encodings (shared with the instruction controller)
    typedef enum logic [2:0] {
        RdLb  = 3'd0,
        RdLh  = 3'd1,
        RdLw  = 3'd2,
        RdLbu = 3'd4,
        RdLhu = 3'd5
    } lsu_rd_type_e;

    // Store type encodings; 2'd3 is invalid
    typedef enum logic [1:0] {
        WrSb = 2'd0,
        WrSh = 2'd1,
        WrSw = 2'd2
    } lsu_wr_type_e;

    typedef enum logic [1:0] {
        FaultNone     = 2'd0,
        FaultMisalign = 2'd1,
        FaultBadType  = 2'd2,
        FaultTimeout  = 2'd3
    } lsu_fault_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } lsu_state_e;

    // Access size as carried in the low two bits of both type encodings
    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    function automatic logic rd_type_valid(input logic [2:0] t);
        return (t == RdLb) || (t == RdLh) || (t == RdLw) || (t == RdLbu) || (t == RdLhu);
    endfunction

    function automatic logic wr_type_valid(input logic [1:0] t);
        return t != 2'd3;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SizeHalf) && off[0]) || ((size == SizeWord) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [1:0]  offset,
    input  logic [31:0] wr_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd_ext
);

    logic [31:0] sel;

    // Byte enables and lane-replicated store data
    always_comb begin
        be    = 4'b1111;
        wdata = wr_data;
        case (size)
            SizeByte: begin
                be    = 4'b0001 << offset;
                wdata = {4{wr_data[7:0]}};
            end
            SizeHalf: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{wr_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wr_data;
            end
        endcase
    end

    // Shift the addressed lane down and extend to 32 bits
    always_comb begin
        sel    = rdata >> {offset, 3'b000};
        rd_ext = sel;
        case (size)
            SizeByte: rd_ext = {{24{~load_unsigned & sel[7]}}, sel[7:0]};
            SizeHalf: rd_ext = {{16{~load_unsigned & sel[15]}}, sel[15:0]};
            default:  rd_ext = sel;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one handshaked load or store per request, with
// alignment/type checks, a REQ+WAIT timeout and a pipeline stall.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [2:0]        mem_rd_type,
    input  logic [1:0]        mem_wr_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              lsu_stall,
    output logic              lsu_done,
    output logic [1:0]        fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata
);

    localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

    lsu_state_e        state_q, state_d;
    lsu_fault_e        fault_q, fault_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [ADDR_W-1:0] addr_q;
    logic              is_store_q;
    logic [2:0]        rd_type_q;
    logic [1:0]        wr_type_q;
    logic [31:0]       wr_data_q;
    logic [31:0]       rd_data_q;

    logic              capture;
    logic              rd_we;
    logic              rd_clr;
    logic              timeout_hit;
    logic [1:0]        req_size;
    logic              req_bad;
    logic              req_mis;
    logic [1:0]        cur_size;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rd_ext;

    // Incoming request decode; store wins when both enables are set
    always_comb begin
        req_size = mem_wr_en ? mem_wr_type : mem_rd_type[1:0];
        req_bad  = mem_wr_en ? !wr_type_valid(mem_wr_type) : !rd_type_valid(mem_rd_type);
        req_mis  = misaligned(req_size, addr[1:0]);
        cur_size = is_store_q ? wr_type_q : rd_type_q[1:0];
    end

    assign timeout_hit = (timer_q == TimerW'(TIMEOUT - 1));

    lsu_align u_align (
        .size          (cur_size),
        .load_unsigned (rd_type_q[2]),
        .offset        (addr_q[1:0]),
        .wr_data       (wr_data_q),
        .rdata         (dmem_rdata),
        .be            (be),
        .wdata         (wdata),
        .rd_ext        (rd_ext)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, fault selection and datapath write strobes
    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        timer_d = '0;
        capture = 1'b0;
        rd_we   = 1'b0;
        rd_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_rd_en || mem_wr_en) begin
                    capture = 1'b1;
                    if (req_bad) begin
                        state_d = StDone;
                        fault_d = FaultBadType;
                        rd_clr  = !mem_wr_en;
                    end else if (req_mis) begin
                        state_d = StDone;
                        fault_d = FaultMisalign;
                        rd_clr  = !mem_wr_en;
                    end else begin
                        state_d = StReq;
                        fault_d = FaultNone;
                    end
                end
            end
            StReq: begin
                timer_d = timer_q + 1'b1;
                // Completion on the last allowed cycle beats the timeout
                if (dmem_gnt && is_store_q) begin
                    state_d = StDone;
                    fault_d = FaultNone;
                end else if (dmem_gnt && dmem_rvalid) begin
                    state_d = StDone;
                    fault_d = FaultNone;
                    rd_we   = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StDone;
                    fault_d = FaultTimeout;
                    rd_clr  = !is_store_q;
                end else if (dmem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                timer_d = timer_q + 1'b1;
                if (dmem_rvalid) begin
                    state_d = StDone;
                    fault_d = FaultNone;
                    rd_we   = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StDone;
                    fault_d = FaultTimeout;
                    rd_clr  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Request capture, timer, fault code and load result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q    <= '0;
            fault_q    <= FaultNone;
            addr_q     <= '0;
            is_store_q <= 1'b0;
            rd_type_q  <= '0;
            wr_type_q  <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            timer_q <= timer_d;
            fault_q <= fault_d;
            if (capture) begin
                addr_q     <= addr;
                is_store_q <= mem_wr_en;
                rd_type_q  <= mem_rd_type;
                wr_type_q  <= mem_wr_type;
                wr_data_q  <= wr_data;
            end
            if (rd_we) begin
                rd_data_q <= rd_ext;
            end else if (rd_clr) begin
                rd_data_q <= '0;
            end
        end
    end

    // Bus and pipeline outputs; bus fields are only driven while requesting
    always_comb begin
        dmem_req   = (state_q == StReq);
        dmem_we    = dmem_req && is_store_q;
        dmem_addr  = dmem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        dmem_be    = dmem_req ? be : 4'b0000;
        dmem_wdata = (dmem_req && is_store_q) ? wdata : 32'h0;
        lsu_done   = (state_q == StDone);
        fault      = lsu_done ? fault_q : FaultNone;
        // Gated by reset so the pipeline is released while reset is held
        lsu_stall  = rst_n && (mem_rd_en || mem_wr_en) && (state_q != StDone);
        rd_data    = rd_data_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses checked against a transaction-level reference model.
module tb_load_store_unit;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd_en = 1'b0;
    logic        mem_wr_en = 1'b0;
    logic [2:0]  mem_rd_type = '0;
    logic [1:0]  mem_wr_type = '0;
    logic [31:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        lsu_stall;
    logic        lsu_done;
    logic [1:0]  fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd = '0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT (T),
        .ADDR_W  (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_rd_en   (mem_rd_en),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_type (mem_rd_type),
        .mem_wr_type (mem_wr_type),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .lsu_stall   (lsu_stall),
        .lsu_done    (lsu_done),
        .fault       (fault),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Access width in bytes for a load or store type (0 = invalid type)
    function automatic int nbytes_of(input bit st, input logic [2:0] rt, input logic [1:0] wt);
        if (st) begin
            case (wt)
                2'd0: return 1;
                2'd1: return 2;
                2'd2: return 4;
                default: return 0;
            endcase
        end
        case (rt)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] ext_load(input logic [2:0] rt, input logic [31:0] w,
                                             input logic [1:0] o);
        logic [31:0] sel;
        sel = w >> (8 * o);
        case (rt)
            3'd0:    return 32'($signed(sel[7:0]));
            3'd1:    return 32'($signed(sel[15:0]));
            3'd4:    return {24'h0, sel[7:0]};
            3'd5:    return {16'h0, sel[15:0]};
            default: return sel;
        endcase
    endfunction

    // One access: g = cycle (after leaving IDLE) on which gnt is given, r = cycle of rvalid
    task automatic access(input string name, input bit rd, input bit wr, input logic [2:0] rt,
                          input logic [1:0] wt, input logic [31:0] a, input logic [31:0] wd,
                          input int g, input int r, input logic [31:0] rdw);
        bit          st;
        int          nb;
        int          f;
        int          done_j;
        bit          ok_load;
        logic [1:0]  o;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        st = wr;
        o  = a[1:0];
        nb = nbytes_of(st, rt, wt);
        if (nb == 0) f = 2;
        else if ((int'(o) % nb) != 0) f = 1;
        else f = 0;
        if (f != 0) done_j = 0;
        else if (st) done_j = (g < int'(T)) ? g + 1 : int'(T);
        else done_j = (r < int'(T)) ? r + 1 : int'(T);
        ok_load = !st && (f == 0) && (r < int'(T));
        if (f != 0 && f != 0 && !st) f = f;
        if (f == 0 && !st && r >= int'(T)) f = 3;
        if (f == 0 && st && g >= int'(T)) f = 3;
        exp_be = (nb == 1) ? (4'b0001 << o) : (nb == 2) ? (o[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        exp_wd = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;

        @(negedge clk);
        mem_rd_en   = rd;
        mem_wr_en   = wr;
        mem_rd_type = rt;
        mem_wr_type = wt;
        addr        = a;
        wr_data     = wd;
        dmem_rdata  = rdw;
        for (int j = 0; j < done_j; j++) begin
            @(posedge clk);
            #1;
            chk({name, " busy_done"}, 32'(lsu_done), 32'(0));
            chk({name, " busy_stall"}, 32'(lsu_stall), 32'(1));
            chk({name, " req"}, 32'(dmem_req), 32'(j <= g));
            if (j == 0) begin
                chk({name, " addr"}, dmem_addr, {a[31:2], 2'b00});
                chk({name, " be"}, 32'(dmem_be), 32'(exp_be));
                chk({name, " we"}, 32'(dmem_we), 32'(st));
                if (st) chk({name, " wdata"}, dmem_wdata, exp_wd);
            end
            dmem_gnt    = (j == g);
            dmem_rvalid = !st && (j == r);
        end
        @(posedge clk);
        #1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (!st) model_rd = ok_load ? ext_load(rt, rdw, o) : 32'h0;
        chk({name, " done"}, 32'(lsu_done), 32'(1));
        chk({name, " done_stall"}, 32'(lsu_stall), 32'(0));
        chk({name, " done_req"}, 32'(dmem_req), 32'(0));
        chk({name, " fault"}, 32'(fault), 32'(f));
        chk({name, " rd_data"}, rd_data, model_rd);
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        @(posedge clk);
        #1;
        chk({name, " after_done"}, 32'(lsu_done), 32'(0));
        chk({name, " after_fault"}, 32'(fault), 32'(0));
        chk({name, " held_rd"}, rd_data, model_rd);
    endtask

    initial begin
        // Reset state, with a request pending to show the stall is released
        mem_rd_en = 1'b1;
        #12;
        chk("rst rd_data", rd_data, 32'h0);
        chk("rst stall", 32'(lsu_stall), 32'(0));
        chk("rst done", 32'(lsu_done), 32'(0));
        chk("rst fault", 32'(fault), 32'(0));
        chk("rst req", 32'(dmem_req), 32'(0));
        chk("rst bus", {dmem_addr[27:0], dmem_be}, 32'h0);
        chk("rst we_wdata", dmem_wdata | 32'(dmem_we), 32'h0);
        mem_rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: LW with gnt on cycle 1 and rvalid on cycle 3
        access("t1_lw", 1'b1, 1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 1, 3, 32'hDEADBEEF);
        chk("t1 rd_const", rd_data, 32'hDEADBEEF);
        // 2: LB / LBU from the top byte
        access("t2_lb", 1'b1, 1'b0, 3'd0, 2'd0, 32'h103, 32'h0, 0, 0, 32'h80123456);
        chk("t2 lb_const", rd_data, 32'hFFFFFF80);
        access("t2_lbu", 1'b1, 1'b0, 3'd4, 2'd0, 32'h103, 32'h0, 0, 1, 32'h80123456);
        chk("t2 lbu_const", rd_data, 32'h00000080);
        // 3: SH to upper half, immediate gnt
        access("t3_sh", 1'b0, 1'b1, 3'd0, 2'd1, 32'h102, 32'h1234ABCD, 0, 0, 32'h0);
        // 4: misaligned LW and bad load type
        access("t4_mis", 1'b1, 1'b0, 3'd2, 2'd0, 32'h101, 32'h0, 0, 0, 32'h55555555);
        chk("t4 mis_rd0", rd_data, 32'h0);
        access("t4_lhu", 1'b1, 1'b0, 3'd5, 2'd0, 32'h106, 32'h0, 0, 2, 32'hBEEF0000);
        access("t4_bad", 1'b1, 1'b0, 3'd3, 2'd0, 32'h104, 32'h0, 0, 0, 32'h55555555);
        chk("t4 bad_rd0", rd_data, 32'h0);
        // 5: store timeout, then a late gnt/rvalid must be ignored
        access("t5_sto", 1'b0, 1'b1, 3'd0, 2'd2, 32'h200, 32'hCAFEF00D, 99, 99, 32'h0);
        dmem_gnt    = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h77777777;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("t5 late_req", 32'(dmem_req), 32'(0));
            chk("t5 late_done", 32'(lsu_done), 32'(0));
            chk("t5 late_rd", rd_data, model_rd);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        access("t5_lto", 1'b1, 1'b0, 3'd2, 2'd0, 32'h204, 32'h0, 1, 99, 32'h12345678);
        access("t5_edge", 1'b1, 1'b0, 3'd2, 2'd0, 32'h208, 32'h0, 3, 3, 32'h0BADF00D);

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            int          kind;
            int          g;
            int          r;
            kind = $urandom_range(0, 2);
            g    = $urandom_range(0, 5);
            r    = g + $urandom_range(0, 3);
            access($sformatf("rnd%0d", n), kind != 1, kind != 0, 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), $urandom, $urandom, g, r, $urandom);
        end

        // 6: reset asserted while a load waits for rvalid
        access("t6_pre", 1'b1, 1'b0, 3'd2, 2'd0, 32'h300, 32'h0, 0, 0, 32'hA5A5A5A5);
        @(negedge clk);
        mem_rd_en   = 1'b1;
        mem_rd_type = 3'd2;
        addr        = 32'h304;
        @(posedge clk);
        #1;
        chk("t6 req", 32'(dmem_req), 32'(1));
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        chk("t6 wait_req", 32'(dmem_req), 32'(0));
        chk("t6 wait_stall", 32'(lsu_stall), 32'(1));
        rst_n = 1'b0;
        #1;
        model_rd = 32'h0;
        chk("t6 rst_req", 32'(dmem_req), 32'(0));
        chk("t6 rst_stall", 32'(lsu_stall), 32'(0));
        chk("t6 rst_rd", rd_data, 32'h0);
        chk("t6 rst_done", 32'(lsu_done), 32'(0));
        @(negedge clk);
        mem_rd_en = 1'b0;
        rst_n     = 1'b1;
        access("t6_post", 1'b1, 1'b0, 3'd1, 2'd0, 32'h30A, 32'h0, 0, 1, 32'h8001FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
